// File: rtl/ghost_move_scheduler.sv
// rtl/ghost_move_scheduler.sv - round-robin ghost move scheduler over one shared probe/distance/select datapath
module ghost_move_scheduler #(
  parameter int NUM_GHOSTS = 4,
  parameter int ID_W       = 2
) (
  input  logic                    clk_i,
  input  logic                    resetn_i,
  input  logic                    tick_i,
  input  logic [NUM_GHOSTS-1:0]   ghost_req_i,
  input  logic [16*NUM_GHOSTS-1:0] ghost_loc_i,
  input  logic [16*NUM_GHOSTS-1:0] target_loc_i,
  input  logic [2*NUM_GHOSTS-1:0] prev_dir_i,
  input  logic [NUM_GHOSTS-1:0]   fright_i,
  input  logic [1:0]              rand_dir_i,
  output logic                    wall_rd_o,
  output logic [15:0]             wall_addr_o,
  input  logic                    wall_clear_i,
  output logic                    busy_o,
  output logic                    move_valid_o,
  output logic [ID_W-1:0]         move_id_o,
  output logic [15:0]             move_dir_o,
  output logic [15:0]             move_loc_o,
  output logic [1:0]              move_idx_o,
  output logic                    round_done_o,
  output logic                    overrun_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_PROBE, S_EVAL, S_EMIT, S_DONE
  } state_t;

  state_t                state_q;
  logic [NUM_GHOSTS-1:0] pend_q;
  logic [ID_W-1:0]       rr_ptr_q, grant_q;
  logic [15:0]           g_loc_q, tgt_q;
  logic [1:0]            prev_q;
  logic                  fright_q;
  logic [2:0]            pcnt_q;
  logic [3:0]            clear_q;
  logic                  wall_rd_q, busy_q, move_valid_q, round_done_q, overrun_q;
  logic [15:0]           wall_addr_q, move_dir_q, move_loc_q;
  logic [ID_W-1:0]       move_id_q;
  logic [1:0]            move_idx_q;

  logic [ID_W-1:0]       grant_d;
  logic [15:0]           sel_loc_d, sel_tgt_d;
  logic [1:0]            sel_prev_d;
  logic                  sel_fright_d;
  logic [3:0]            cand_d;
  logic [16:0]           dist_d [4];
  logic [1:0]            pick_d;
  logic                  found_d;

  // Neighbour tile: per-byte wrap so tunnels work and x/y never carry into each other.
  function automatic logic [15:0] nbr(input logic [15:0] loc, input logic [1:0] d);
    case (d)
      2'd0:    nbr = {loc[15:8] - 8'd1, loc[7:0]};
      2'd1:    nbr = {loc[15:8] + 8'd1, loc[7:0]};
      2'd2:    nbr = {loc[15:8], loc[7:0] + 8'd1};
      default: nbr = {loc[15:8], loc[7:0] - 8'd1};
    endcase
  endfunction

  function automatic logic [15:0] dir_vec(input logic [1:0] d);
    case (d)
      2'd0:    dir_vec = 16'hFF00;
      2'd1:    dir_vec = 16'h0100;
      2'd2:    dir_vec = 16'h0001;
      default: dir_vec = 16'h00FF;
    endcase
  endfunction

  function automatic logic [16:0] sqdist(input logic [15:0] a, input logic [15:0] b);
    logic [7:0] dx, dy;
    dx = (a[15:8] > b[15:8]) ? a[15:8] - b[15:8] : b[15:8] - a[15:8];
    dy = (a[7:0] > b[7:0]) ? a[7:0] - b[7:0] : b[7:0] - a[7:0];
    sqdist = 17'(dx) * 17'(dx) + 17'(dy) * 17'(dy);
  endfunction

  // Chase tie priority order U, L, D, R.
  function automatic logic [1:0] prio(input int k);
    case (k)
      0:       prio = 2'd3;
      1:       prio = 2'd0;
      2:       prio = 2'd2;
      default: prio = 2'd1;
    endcase
  endfunction

  always_comb begin
    grant_d = '0;
    for (int k = NUM_GHOSTS - 1; k >= 0; k--) begin
      if (pend_q[(int'(rr_ptr_q) + k) % NUM_GHOSTS])
        grant_d = ID_W'((int'(rr_ptr_q) + k) % NUM_GHOSTS);
    end
    sel_loc_d    = ghost_loc_i[16*int'(grant_d) +: 16];
    sel_tgt_d    = target_loc_i[16*int'(grant_d) +: 16];
    sel_prev_d   = prev_dir_i[2*int'(grant_d) +: 2];
    sel_fright_d = fright_i[grant_d];
  end

  always_comb begin
    logic [16:0] best;
    logic [1:0]  d;
    best    = 17'h1FFFF;
    pick_d  = 2'd0;
    found_d = 1'b0;
    for (int i = 0; i < 4; i++)
      dist_d[i] = clear_q[i] ? sqdist(nbr(g_loc_q, 2'(i)), tgt_q) : 17'h1FFFF;
    cand_d = clear_q & ~(4'b0001 << (prev_q ^ 2'd1));
    if (cand_d == 4'd0)
      cand_d = clear_q & (4'b0001 << (prev_q ^ 2'd1));
    if (fright_q) begin
      for (int k = 3; k >= 0; k--) begin
        d = rand_dir_i + 2'(k);
        if (cand_d[d]) begin
          pick_d  = d;
          found_d = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        d = prio(k);
        if (cand_d[d] && (!found_d || dist_d[d] < best)) begin
          best    = dist_d[d];
          pick_d  = d;
          found_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q      <= S_IDLE;
      pend_q       <= '0;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      g_loc_q      <= '0;
      tgt_q        <= '0;
      prev_q       <= '0;
      fright_q     <= 1'b0;
      pcnt_q       <= '0;
      clear_q      <= '0;
      wall_rd_q    <= 1'b0;
      wall_addr_q  <= '0;
      busy_q       <= 1'b0;
      move_valid_q <= 1'b0;
      move_id_q    <= '0;
      move_dir_q   <= '0;
      move_loc_q   <= '0;
      move_idx_q   <= '0;
      round_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      move_valid_q <= 1'b0;
      round_done_q <= 1'b0;
      if (tick_i && state_q != S_IDLE)
        overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: if (tick_i) begin
          pend_q <= ghost_req_i;
          if (ghost_req_i == '0) begin
            round_done_q <= 1'b1;
          end else begin
            busy_q  <= 1'b1;
            state_q <= S_SELECT;
          end
        end
        S_SELECT: begin
          grant_q         <= grant_d;
          pend_q[grant_d] <= 1'b0;
          g_loc_q         <= sel_loc_d;
          tgt_q           <= sel_tgt_d;
          prev_q          <= sel_prev_d;
          fright_q        <= sel_fright_d;
          wall_rd_q       <= 1'b1;
          wall_addr_q     <= nbr(sel_loc_d, 2'd0);
          pcnt_q          <= '0;
          clear_q         <= '0;
          state_q         <= S_PROBE;
        end
        S_PROBE: begin
          // RAM answers one cycle late, so cycle p captures the tile probed in p-1.
          if (pcnt_q != 3'd0)
            clear_q[pcnt_q[1:0] - 2'd1] <= wall_clear_i;
          if (pcnt_q < 3'd3)
            wall_addr_q <= nbr(g_loc_q, pcnt_q[1:0] + 2'd1);
          else
            wall_rd_q <= 1'b0;
          if (pcnt_q == 3'd4)
            state_q <= S_EVAL;
          else
            pcnt_q <= pcnt_q + 3'd1;
        end
        S_EVAL: begin
          move_valid_q <= 1'b1;
          move_id_q    <= grant_q;
          move_dir_q   <= found_d ? dir_vec(pick_d) : 16'h0000;
          move_loc_q   <= found_d ? nbr(g_loc_q, pick_d) : g_loc_q;
          move_idx_q   <= found_d ? pick_d : 2'd0;
          state_q      <= S_EMIT;
        end
        S_EMIT: begin
          if (pend_q != '0) begin
            state_q <= S_SELECT;
          end else begin
            round_done_q <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        default: begin
          rr_ptr_q <= (rr_ptr_q == ID_W'(NUM_GHOSTS - 1)) ? '0 : rr_ptr_q + 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign wall_rd_o    = wall_rd_q;
  assign wall_addr_o  = wall_addr_q;
  assign busy_o       = busy_q;
  assign move_valid_o = move_valid_q;
  assign move_id_o    = move_id_q;
  assign move_dir_o   = move_dir_q;
  assign move_loc_o   = move_loc_q;
  assign move_idx_o   = move_idx_q;
  assign round_done_o = round_done_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_ghost_move_scheduler.sv
// tb/tb_ghost_move_scheduler.sv - directed self-checking bench for ghost_move_scheduler
module tb_ghost_move_scheduler;

  logic        clk = 1'b0;
  logic        resetn, tick, wall_clear;
  logic [3:0]  ghost_req, fright;
  logic [63:0] ghost_loc, target_loc;
  logic [7:0]  prev_dir;
  logic [1:0]  rand_dir;
  logic        wall_rd, busy, move_valid, round_done, overrun;
  logic [15:0] wall_addr, move_dir, move_loc;
  logic [1:0]  move_id, move_idx;
  logic [15:0] blk [4];

  int checks = 0;
  int errors = 0;
  int n_neg  = 0;
  int cnt;

  ghost_move_scheduler #(.NUM_GHOSTS(4), .ID_W(2)) dut (
    .clk_i(clk), .resetn_i(resetn), .tick_i(tick),
    .ghost_req_i(ghost_req), .ghost_loc_i(ghost_loc), .target_loc_i(target_loc),
    .prev_dir_i(prev_dir), .fright_i(fright), .rand_dir_i(rand_dir),
    .wall_rd_o(wall_rd), .wall_addr_o(wall_addr), .wall_clear_i(wall_clear),
    .busy_o(busy), .move_valid_o(move_valid), .move_id_o(move_id),
    .move_dir_o(move_dir), .move_loc_o(move_loc), .move_idx_o(move_idx),
    .round_done_o(round_done), .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  // Wall RAM model: one-cycle read latency, walkable unless listed in blk.
  always @(posedge clk)
    wall_clear <= wall_rd && !(wall_addr == blk[0] || wall_addr == blk[1] ||
                               wall_addr == blk[2] || wall_addr == blk[3]);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    n_neg++;
  endtask

  task automatic do_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    n_neg = 1;
  endtask

  task automatic expect_move(input string tag, input int exp_n, input logic [1:0] id,
                             input logic [15:0] dir, input logic [15:0] loc, input logic [1:0] idx);
    int guard = 0;
    while (move_valid !== 1'b1 && guard < 60) begin
      step();
      guard++;
    end
    chk({tag, "_lat"}, 64'(n_neg), 64'(exp_n));
    chk({tag, "_res"}, {28'd0, move_valid, move_id, move_dir, move_loc, move_idx},
        {28'd0, 1'b1, id, dir, loc, idx});
    step();
  endtask

  task automatic expect_done(input string tag, input int exp_n);
    int guard = 0;
    while (round_done !== 1'b1 && guard < 60) begin
      step();
      guard++;
    end
    chk({tag, "_done"}, 64'(n_neg), 64'(exp_n));
    step();
  endtask

  task automatic settle();
    repeat (3) step();
  endtask

  task automatic set_ghost(input int i, input logic [15:0] loc, input logic [15:0] tgt,
                           input logic [1:0] pd, input logic fr);
    ghost_loc[16*i +: 16]  = loc;
    target_loc[16*i +: 16] = tgt;
    prev_dir[2*i +: 2]     = pd;
    fright[i]              = fr;
  endtask

  initial begin
    resetn = 1'b0; tick = 1'b0; ghost_req = '0; fright = '0;
    ghost_loc = '0; target_loc = '0; prev_dir = '0; rand_dir = '0;
    for (int i = 0; i < 4; i++) blk[i] = 16'hFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step();
      chk("reset_outs", {7'd0, wall_rd, wall_addr, busy, move_valid, move_id,
                         move_dir, move_loc, move_idx, round_done, overrun}, 64'd0);
    end

    // Single ghost chase with probe address sequence L,R,D,U.
    set_ghost(0, 16'h1010, 16'h1020, 2'd2, 1'b0);
    ghost_req = 4'b0001;
    do_tick();
    step(); chk("probe_L", {wall_rd, wall_addr}, {1'b1, 16'h0F10});
    step(); chk("probe_R", {wall_rd, wall_addr}, {1'b1, 16'h1110});
    step(); chk("probe_D", {wall_rd, wall_addr}, {1'b1, 16'h1011});
    step(); chk("probe_U", {wall_rd, wall_addr}, {1'b1, 16'h100F});
    step(); chk("probe_end", 64'(wall_rd), 64'd0);
    chk("busy", 64'(busy), 64'd1);
    expect_move("single", 8, 2'd0, 16'h0001, 16'h1011, 2'd2);
    expect_done("single", 9);
    settle();

    // Equal distances: reverse (R) excluded, U wins the tie.
    set_ghost(0, 16'h1010, 16'h1010, 2'd0, 1'b0);
    do_tick();
    expect_move("tie", 8, 2'd0, 16'h00FF, 16'h100F, 2'd3);
    expect_done("tie", 9);
    settle();

    // Dead end: only the reverse tile is walkable.
    set_ghost(0, 16'h2020, 16'h2020, 2'd0, 1'b0);
    blk[0] = 16'h1F20; blk[1] = 16'h2021; blk[2] = 16'h201F;
    do_tick();
    expect_move("deadend", 8, 2'd0, 16'h0100, 16'h2120, 2'd1);
    expect_done("deadend", 9);
    settle();

    // Fully boxed in: no move.
    blk[3] = 16'h2120;
    do_tick();
    expect_move("blocked", 8, 2'd0, 16'h0000, 16'h2020, 2'd0);
    expect_done("blocked", 9);
    settle();
    for (int i = 0; i < 4; i++) blk[i] = 16'hFFFF;

    // Four ghosts, two rounds: rotation advances by one per round; g1 wraps y=00 -> FF.
    set_ghost(0, 16'h1010, 16'h1010, 2'd0, 1'b0);
    set_ghost(1, 16'h3000, 16'h30F0, 2'd0, 1'b0);
    set_ghost(2, 16'h5050, 16'h6050, 2'd3, 1'b0);
    set_ghost(3, 16'h8080, 16'h8070, 2'd3, 1'b0);
    ghost_req = 4'b1111;
    do_tick();
    expect_move("rr1_g0", 8,  2'd0, 16'h00FF, 16'h100F, 2'd3);
    expect_move("rr1_g1", 16, 2'd1, 16'h00FF, 16'h30FF, 2'd3);
    expect_move("rr1_g2", 24, 2'd2, 16'h0100, 16'h5150, 2'd1);
    expect_move("rr1_g3", 32, 2'd3, 16'h00FF, 16'h807F, 2'd3);
    expect_done("rr1", 33);
    settle();
    do_tick();
    expect_move("rr2_g1", 8,  2'd1, 16'h00FF, 16'h30FF, 2'd3);
    expect_move("rr2_g2", 16, 2'd2, 16'h0100, 16'h5150, 2'd1);
    expect_move("rr2_g3", 24, 2'd3, 16'h00FF, 16'h807F, 2'd3);
    expect_move("rr2_g0", 32, 2'd0, 16'h00FF, 16'h100F, 2'd3);
    expect_done("rr2", 33);
    settle();
    chk("no_overrun_yet", 64'(overrun), 64'd0);

    // Frightened: scan from D (blocked), U clear; second tick mid-round sets overrun.
    set_ghost(0, 16'h4040, 16'h4040, 2'd0, 1'b1);
    ghost_req = 4'b0001;
    rand_dir = 2'd2;
    blk[0] = 16'h4041;
    do_tick();
    step(); step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    expect_move("fright", 8, 2'd0, 16'h00FF, 16'h403F, 2'd3);
    expect_done("fright", 9);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (round_done === 1'b1 || move_valid === 1'b1) cnt++;
    end
    chk("single_round", 64'(cnt), 64'd0);
    chk("overrun", {overrun, busy}, {1'b1, 1'b0});
    blk[0] = 16'hFFFF;
    fright = '0;

    // Reset mid-probe aborts the round and clears overrun.
    do_tick();
    step(); step(); step();
    chk("abort_pre", 64'(wall_rd), 64'd1);
    resetn = 1'b0;
    step();
    chk("abort_outs", {7'd0, wall_rd, wall_addr, busy, move_valid, move_id,
                       move_dir, move_loc, move_idx, round_done, overrun}, 64'd0);
    resetn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (round_done === 1'b1 || move_valid === 1'b1 || wall_rd === 1'b1) cnt++;
    end
    chk("abort_quiet", 64'(cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
